dly_pipe: RTL and testbench

- Parametrised, clock-enabled delay pipeline for the square-magnitude / FFT datapath.
- Carries a WIDTH-bit data word and a valid tag through DEPTH register stages.
- Used to align the magnitude outputs with frame/bin control signals.
- Extends the single-bit async-reset flop with:
  - data width and depth,
  - stall (ce),
  - synchronous flush,
  - occupancy tracking,
  - a primed indicator.

---
 rtl/dly_pipe_pkg.sv | 19 +
 rtl/dly_pipe_stage.sv | 51 +++++
 rtl/dly_pipe.sv | 82 ++++++++
 tb/tb_dly_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dly_pipe_pkg.sv
// Shared limits and sizing helpers for the dly_pipe delay pipeline.
package dly_pipe_pkg;

  localparam int DLY_MAX_WIDTH = 64;
  localparam int DLY_MAX_DEPTH = 64;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= DLY_MAX_WIDTH);
  endfunction

  function automatic bit depth_ok(input int n);
    return (n >= 1) && (n <= DLY_MAX_DEPTH);
  endfunction

endpackage

// File: rtl/dly_pipe_stage.sv
// One data+tag register of the delay pipe; data reset only with
// DLY_PIPE_DATA_RST_EN, otherwise plain enabled flops (SRL friendly).
module dly_pipe_stage
  import dly_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [WIDTH-1:0] q
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("dly_pipe_stage: WIDTH out of range");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= in_valid;
    end
  end

`ifdef DLY_PIPE_DATA_RST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (ce) begin
      q <= d;
    end
  end
`else
  // No reset term so the chain can map onto shift-register primitives.
  always_ff @(posedge clk) begin
    if (ce && !flush) begin
      q <= d;
    end
  end
`endif

endmodule

// File: rtl/dly_pipe.sv
// Clock-enabled data+valid delay line with occupancy and primed status.
// Optional data reset/clear: define DLY_PIPE_DATA_RST_EN.
module dly_pipe
  import dly_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           d,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           q,
  output logic [cnt_w(DEPTH)-1:0]    occ,
  output logic                       primed
);

  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (!depth_ok(DEPTH) || !width_ok(WIDTH)) begin : g_bad_param
    $error("dly_pipe: WIDTH or DEPTH out of range");
  end

  logic [DEPTH:0][WIDTH-1:0] data;
  logic [DEPTH:0]            tag;
  logic [CW-1:0]             fill;
  logic [CW-1:0]             fill_nxt;

  assign data[0] = d;
  assign tag[0]  = in_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dly_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .flush    (flush),
      .in_valid (tag[k]),
      .d        (data[k]),
      .out_valid(tag[k+1]),
      .q        (data[k+1])
    );
  end

  assign q         = data[DEPTH];
  assign out_valid = tag[DEPTH];

  always_comb begin
    fill_nxt = fill;
    if (fill != FULL) begin
      fill_nxt = fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      fill   <= '0;
      primed <= 1'b0;
    end else if (flush) begin
      occ    <= '0;
      fill   <= '0;
      primed <= 1'b0;
    end else if (ce) begin
      // Enter and exit in the same edge cancel out.
      occ    <= occ + CW'(in_valid) - CW'(out_valid);
      fill   <= fill_nxt;
      primed <= (fill_nxt == FULL);
    end
  end

  a_occ_range : assert property (
    @(posedge clk) disable iff (rst) occ <= FULL
  );

endmodule

// File: tb/tb_dly_pipe.sv
// Directed bench for dly_pipe at DEPTH=4 and DEPTH=1 with a
// history-queue reference model checked every cycle.
module tb_dly_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        flush;
  logic        in_valid;
  logic [15:0] d;

  logic        ov4, pr4, ov1, pr1;
  logic [15:0] q4, q1;
  logic [2:0]  occ4;
  logic [0:0]  occ1;

  int vectors = 0;
  int miscompares = 0;

  logic [16:0] hist[$];

  int b_ov[9]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
  int b_occ[9] = '{1, 1, 2, 3, 2, 2, 1, 0, 0};
  int b_q[9]   = '{0, 0, 0, 'hA, 0, 'hC, 'hD, 0, 0};
  int b_iv[5]  = '{1, 0, 1, 1, 0};
  int b_d[5]   = '{'hA, 'hB, 'hC, 'hD, 'hE};
  int s_q[4]   = '{10, 11, 12, 0};

  always #5 clk = ~clk;

  dly_pipe #(.WIDTH(16), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush),
    .in_valid(in_valid), .d(d),
    .out_valid(ov4), .q(q4), .occ(occ4), .primed(pr4)
  );

  dly_pipe #(.WIDTH(16), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush),
    .in_valid(in_valid), .d(d),
    .out_valid(ov1), .q(q1), .occ(occ1), .primed(pr1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  // Reference: list of samples accepted since reset/flush, newest first.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      hist.delete();
    end else if (ce) begin
      hist.push_front({in_valid, d});
      if (hist.size() > 64) void'(hist.pop_back());
    end
  end

  function automatic void expect_for(input int dep, output logic ev,
                                     output logic [15:0] eq,
                                     output int eo, output logic ep);
    int n;
    n = (hist.size() < dep) ? hist.size() : dep;
    ev = 1'b0;
    eq = '0;
    eo = 0;
    for (int i = 0; i < n; i++) eo += int'(hist[i][16]);
    ep = (hist.size() >= dep);
    if (ep) begin
      ev = hist[dep-1][16];
      eq = hist[dep-1][15:0];
    end
  endfunction

  always @(negedge clk) begin
    logic ev, ep;
    logic [15:0] eq;
    int eo;
    expect_for(4, ev, eq, eo, ep);
    chk("m4_ov", ov4, ev);
    chk("m4_occ", occ4, eo);
    chk("m4_primed", pr4, ep);
    if (ev) chk("m4_q", q4, eq);
    expect_for(1, ev, eq, eo, ep);
    chk("m1_ov", ov1, ev);
    chk("m1_occ", occ1, eo);
    chk("m1_primed", pr1, ep);
    if (ev) chk("m1_q", q1, eq);
  end

  task automatic step(input logic c, input logic f, input logic v,
                      input logic [15:0] x);
    ce = c;
    flush = f;
    in_valid = v;
    d = x;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    d = '0;
    repeat (2) @(negedge clk);
    chk("rst_ov", ov4, 0);
    chk("rst_occ", occ4, 0);
    chk("rst_primed", pr4, 0);
    chk("rst_primed1", pr1, 0);
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, 16'(i));
      chk("lat_occ", occ4, (i < 4) ? i : 4);
      chk("lat_primed", pr4, (i >= 4) ? 1 : 0);
      if (i >= 4) begin
        chk("lat_ov", ov4, 1);
        chk("lat_q", q4, i - 3);
      end
    end

    step(1, 0, 1, 16'd9);
    step(1, 0, 1, 16'd10);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 16'h77);
      chk("stall_q", q4, 7);
      chk("stall_occ", occ4, 4);
      chk("stall_ov", ov4, 1);
    end
    step(1, 0, 1, 16'd11);
    chk("resume_q", q4, 8);
    step(1, 0, 1, 16'd12);
    chk("resume_q", q4, 9);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 16'h0);
      chk("drain_ov", ov4, (i < 3) ? 1 : 0);
      chk("drain_occ", occ4, 3 - i);
      if (i < 3) chk("drain_q", q4, s_q[i]);
    end

    for (int k = 0; k < 9; k++) begin
      if (k < 5) step(1, 0, b_iv[k][0], 16'(b_d[k]));
      else step(1, 0, 0, 16'h0);
      chk("bub_ov", ov4, b_ov[k]);
      chk("bub_occ", occ4, b_occ[k]);
      if (b_ov[k] != 0) chk("bub_q", q4, b_q[k]);
    end

    step(1, 0, 1, 16'h21);
    step(1, 0, 1, 16'h22);
    step(1, 0, 1, 16'h23);
    chk("pre_flush_occ", occ4, 3);
    step(1, 1, 1, 16'h99);
    chk("flush_ov", ov4, 0);
    chk("flush_occ", occ4, 0);
    chk("flush_primed", pr4, 0);
    chk("flush_primed1", pr1, 0);
    chk("flush_occ1", occ1, 0);
    for (int j = 1; j <= 4; j++) begin
      step(1, 0, 0, 16'h0);
      chk("post_flush_ov", ov4, 0);
      chk("post_flush_primed", pr4, (j >= 4) ? 1 : 0);
    end

    for (int i = 0; i < 4; i++) step(1, 0, 1, 16'(16'h31 + i));
    chk("full_occ", occ4, 4);
    chk("full_q", q4, 16'h31);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", ov4, 0);
    chk("arst_occ", occ4, 0);
    chk("arst_primed", pr4, 0);
    chk("arst_ov1", ov1, 0);
    chk("arst_primed1", pr1, 0);
`ifdef DLY_PIPE_DATA_RST_EN
    chk("arst_q", q4, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    chk("d1_primed0", pr1, 0);
    step(1, 0, 1, 16'hFFFF);
    chk("d1_q", q1, 16'hFFFF);
    chk("d1_ov", ov1, 1);
    chk("d1_occ", occ1, 1);
    chk("d1_primed", pr1, 1);
    step(1, 0, 0, 16'h0);
    chk("d1_ov_off", ov1, 0);
    chk("d1_occ_off", occ1, 0);
    step(1, 0, 0, 16'h0);
    chk("d1_ov_off2", ov1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
